// File: rtl/spi_cpu_cpu_debug_pkg.sv
// Shared definitions for the CPU debug monitor access path: FSM states,
// jdo field positions and the default wait-state timeout.
package spi_cpu_cpu_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } mon_state_e;

  localparam int JDO_W           = 38;
  localparam int JDO_RDNOW       = 37;
  localparam int JDO_AUTOINC     = 36;
  localparam int JDO_BE_HI       = 35;
  localparam int JDO_BE_LO       = 32;
  localparam int DEFAULT_TIMEOUT = 255;

  // Byte-enable field of a jdo command word.
  function automatic logic [3:0] jdo_be(input logic [JDO_W-1:0] j);
    return j[JDO_BE_HI:JDO_BE_LO];
  endfunction

  // Write-data field of a jdo command word.
  function automatic logic [31:0] jdo_wdata(input logic [JDO_W-1:0] j);
    return j[31:0];
  endfunction

endpackage

// File: rtl/spi_cpu_cpu_debug_monitor_timer.sv
// Wait-state counter for an outstanding monitor request. Cleared while the
// monitor is idle, counts cycles of waitrequest, and flags the last allowed
// wait cycle so the FSM can abort instead of hanging on a dead target.
module spi_cpu_cpu_debug_monitor_timer
  import spi_cpu_cpu_debug_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [7:0] cnt_q;

  // Counter: clear has priority over count enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else if (clr_i) begin
      cnt_q <= 8'd0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 8'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign term_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/spi_cpu_cpu_debug_monitor_access.sv
// Debug monitor access: turns jdo commands from the debug slave into single
// word reads/writes on a memory master port and reports the result back
// through MonDReg / monitor_ready / monitor_error.
module spi_cpu_cpu_debug_monitor_access
  import spi_cpu_cpu_debug_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  mon_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              autoinc_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       mondreg_q;
  logic              read_q;
  logic              write_q;
  logic              ready_q;
  logic              error_q;

  logic              busy_s;
  logic              any_strobe_s;
  logic              tmr_clr_s;
  logic              tmr_en_s;
  logic              tmr_term_s;

  assign busy_s       = (state_q != ST_IDLE);
  assign any_strobe_s = take_action_ocimem_a | take_action_ocimem_b |
                        take_no_action_ocimem_a;
  // Holding the timer clear while idle guarantees it starts at zero on entry.
  assign tmr_clr_s    = !busy_s;
  assign tmr_en_s     = busy_s & avm_waitrequest;

  spi_cpu_cpu_debug_monitor_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (tmr_clr_s),
    .en_i    (tmr_en_s),
    .term_o  (tmr_term_s)
  );

  // Command FSM and datapath; every output comes straight from a register here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      autoinc_q <= 1'b0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      mondreg_q <= 32'd0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      ready_q   <= 1'b1;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take_action_ocimem_a) begin
            addr_q    <= jdo[ADDR_W-1:0];
            autoinc_q <= jdo[JDO_AUTOINC];
            if (jdo[JDO_RDNOW]) begin
              state_q <= ST_RD;
              read_q  <= 1'b1;
              ready_q <= 1'b0;
              error_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (take_action_ocimem_b) begin
            wdata_q <= jdo_wdata(jdo);
            be_q    <= jdo_be(jdo);
            state_q <= ST_WR;
            write_q <= 1'b1;
            ready_q <= 1'b0;
            error_q <= 1'b0;
          end else if (take_no_action_ocimem_a) begin
            state_q <= ST_RD;
            read_q  <= 1'b1;
            ready_q <= 1'b0;
            error_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_RD, ST_WR: begin
          // A command arriving mid-transfer is lost; remember that it was.
          if (any_strobe_s) begin
            error_q <= 1'b1;
          end
          if (!avm_waitrequest) begin
            if (state_q == ST_RD) begin
              mondreg_q <= avm_readdata;
            end
            if (autoinc_q) begin
              addr_q <= addr_q + ADDR_W'(1);
            end
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else if (tmr_term_s) begin
            // Abort: target never answered, leave address and data alone.
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            error_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= state_q;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
  assign MonDReg        = mondreg_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;

endmodule

// File: tb/tb_spi_cpu_cpu_debug_monitor_access.sv
// Scoreboard bench for the debug monitor access block: a transaction-level
// model predicts each bus request and its final status; a monitor process
// compares them as the DUT presents them.
module tb_spi_cpu_cpu_debug_monitor_access;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_a, take_b, take_na;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error;

  spi_cpu_cpu_debug_monitor_access #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_a),
    .take_action_ocimem_b   (take_b),
    .take_no_action_ocimem_a(take_na),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_write              (avm_write),
    .avm_writedata          (avm_writedata),
    .avm_byteenable         (avm_byteenable),
    .avm_readdata           (avm_readdata),
    .avm_waitrequest        (avm_waitrequest),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- expected-transaction queues ----------------
  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cycles;
  } bus_t;
  typedef struct {
    logic [31:0] mon;
    bit          err;
    logic [7:0]  addr;
  } st_t;

  bus_t bus_q[$];
  st_t  st_q[$];

  // ---------------- reference model state ----------------
  logic [7:0]  m_addr;
  bit          m_auto;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_mon;
  bit          m_err;
  logic [31:0] shadow[256];

  // ---------------- slave (target memory) ----------------
  logic [31:0] smem[256];
  int          slave_waits = 0;
  int          scyc = 0;

  initial begin
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'd0;
    forever begin
      @(negedge clk);
      if (avm_read || avm_write) begin
        if (scyc < slave_waits) begin
          avm_waitrequest = 1'b1;
          avm_readdata    = $urandom;
        end else begin
          avm_waitrequest = 1'b0;
          if (avm_read) avm_readdata = smem[avm_address];
          else begin
            for (int k = 0; k < 4; k++)
              if (avm_byteenable[k]) smem[avm_address][8*k +: 8] = avm_writedata[8*k +: 8];
          end
        end
        scyc++;
      end else begin
        scyc            = 0;
        avm_waitrequest = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  bit   mon_en = 1'b0;
  bit   prev_req = 1'b0;
  bit   prev_rdy = 1'b1;
  bit   have_cur = 1'b0;
  bus_t cur;
  int   len = 0;

  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if ((avm_read || avm_write) && !prev_req) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_request", 64'(avm_address), 64'hFFFF);
          have_cur = 1'b0;
        end else begin
          cur      = bus_q.pop_front();
          have_cur = 1'b1;
          chk("bus_kind_write", 64'(avm_write), 64'(cur.is_wr));
          chk("bus_kind_read", 64'(avm_read), 64'(!cur.is_wr));
          chk("bus_addr", 64'(avm_address), 64'(cur.addr));
          if (cur.is_wr) begin
            chk("bus_wdata", 64'(avm_writedata), 64'(cur.wdata));
            chk("bus_be", 64'(avm_byteenable), 64'(cur.be));
          end
        end
        len = 0;
      end
      if (avm_read || avm_write) len++;
      if (!(avm_read || avm_write) && prev_req && have_cur) begin
        chk("bus_req_cycles", 64'(len), 64'(cur.cycles));
        have_cur = 1'b0;
      end
      if (monitor_ready && !prev_rdy) begin
        if (st_q.size() == 0) begin
          chk("status_unexpected", 64'(MonDReg), 64'hFFFF_FFFF_FFFF);
        end else begin
          st_t s;
          s = st_q.pop_front();
          chk("status_MonDReg", 64'(MonDReg), 64'(s.mon));
          chk("status_error", 64'(monitor_error), 64'(s.err));
          chk("status_addr", 64'(avm_address), 64'(s.addr));
        end
      end
      prev_req = avm_read || avm_write;
      prev_rdy = monitor_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(monitor_ready && !avm_read && !avm_write) && n < 200);
    if (n >= 200) chk("wait_idle_timeout", 64'(n), 64'd0);
  endtask

  task automatic issue(input bit a, input bit b, input bit na,
                       input logic [37:0] j, input int waits, input bit drop);
    bit          start, rd, tmo;
    logic [63:0] r;
    int          sel;
    bus_t        be_e;
    st_t         se;
    start = 1'b0;
    rd    = 1'b0;
    wait_idle();
    slave_waits = waits;
    @(posedge clk); #1;
    take_a = a; take_b = b; take_na = na; jdo = j;
    if (a) begin
      m_addr = j[7:0];
      m_auto = j[36];
      if (j[37]) begin start = 1'b1; rd = 1'b1; end
    end else if (b) begin
      m_wdata = j[31:0];
      m_be    = j[35:32];
      start   = 1'b1;
    end else if (na) begin
      start = 1'b1;
      rd    = 1'b1;
    end
    if (start) begin
      tmo         = (waits >= TIMEOUT);
      m_err       = 1'b0;
      be_e.is_wr  = !rd;
      be_e.addr   = m_addr;
      be_e.wdata  = m_wdata;
      be_e.be     = m_be;
      be_e.cycles = tmo ? TIMEOUT : waits + 1;
      bus_q.push_back(be_e);
      if (tmo) m_err = 1'b1;
      else begin
        if (rd) m_mon = shadow[m_addr];
        else begin
          for (int k = 0; k < 4; k++)
            if (m_be[k]) shadow[m_addr][8*k +: 8] = m_wdata[8*k +: 8];
        end
        if (m_auto) m_addr = 8'((int'(m_addr) + 1) % 256);
      end
      if (drop) m_err = 1'b1;
      se.mon  = m_mon;
      se.err  = m_err;
      se.addr = m_addr;
      st_q.push_back(se);
    end
    @(posedge clk); #1;
    if (start) chk("ready_low_after_start", 64'(monitor_ready), 64'd0);
    take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
    if (start && drop) begin
      sel = $urandom_range(0, 2);
      r   = {$urandom, $urandom};
      jdo = r[37:0];
      take_a  = (sel == 0);
      take_b  = (sel == 1);
      take_na = (sel == 2);
    end
    @(posedge clk); #1;
    take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
    if (start && waits == 0) chk("ready_two_cycles", 64'(monitor_ready), 64'd1);
    if (!start) begin
      chk("idle_ready", 64'(monitor_ready), 64'd1);
      chk("idle_error", 64'(monitor_error), 64'(m_err));
      chk("idle_addr", 64'(avm_address), 64'(m_addr));
      chk("idle_no_req", 64'(avm_read | avm_write), 64'd0);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_avm_read"}, 64'(avm_read), 64'd0);
    chk({tag, "_avm_write"}, 64'(avm_write), 64'd0);
    chk({tag, "_avm_address"}, 64'(avm_address), 64'd0);
    chk({tag, "_avm_writedata"}, 64'(avm_writedata), 64'd0);
    chk({tag, "_avm_byteenable"}, 64'(avm_byteenable), 64'd0);
    chk({tag, "_MonDReg"}, 64'(MonDReg), 64'd0);
    chk({tag, "_ready"}, 64'(monitor_ready), 64'd1);
    chk({tag, "_error"}, 64'(monitor_error), 64'd0);
  endtask

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL global_timeout reached actual=running required=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v;
    logic [63:0] r;
    int          kind, waits, rr;
    bit          drop, rdnow, ainc;
    logic [7:0]  ad;
    bus_t        be_e;
    st_t         se;

    reset_n = 1'b0; jdo = 38'd0;
    take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      smem[i] = v;
      shadow[i] = v;
    end
    smem[16] = 32'hDEAD_BEEF;
    shadow[16] = 32'hDEAD_BEEF;
    m_addr = 8'd0; m_auto = 1'b0; m_wdata = 32'd0; m_be = 4'd0;
    m_mon = 32'd0; m_err = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_reset_values("rst");
    mon_en = 1'b1;

    // read-now + autoinc at 0x10, zero waits
    issue(1'b1, 1'b0, 1'b0, 38'h30_0000_0010, 0, 1'b0);
    // load 0xFF with autoinc, write there, then streaming read wraps to 0x00
    issue(1'b1, 1'b0, 1'b0, 38'h10_0000_00FF, 0, 1'b0);
    issue(1'b0, 1'b1, 1'b0, {2'b00, 4'h3, 32'h1234_5678}, 1, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 38'd0, 0, 1'b0);
    // target hangs: abort after TIMEOUT cycles
    issue(1'b0, 1'b0, 1'b1, 38'd0, 255, 1'b0);
    // exactly TIMEOUT-1 waits still completes
    issue(1'b0, 1'b0, 1'b1, 38'd0, TIMEOUT - 1, 1'b0);
    // ocimem_a + ocimem_b together: only the address load happens
    issue(1'b1, 1'b1, 1'b0, {2'b01, 4'hF, 32'h0000_0042}, 0, 1'b0);
    // strobe during a 3-wait read is dropped and flagged
    issue(1'b0, 1'b0, 1'b1, 38'd0, 3, 1'b1);

    // randomized commands
    for (int it = 0; it < 60; it++) begin
      kind  = $urandom_range(0, 5);
      rr    = $urandom_range(0, 9);
      waits = (rr < 7) ? rr : 255;
      drop  = ($urandom_range(0, 3) == 0);
      rdnow = $urandom_range(0, 1);
      ainc  = $urandom_range(0, 1);
      rr    = $urandom_range(0, 3);
      ad    = (rr == 0) ? 8'hFF : 8'($urandom);
      r     = {$urandom, $urandom};
      case (kind)
        0: issue(1'b1, 1'b0, 1'b0, {1'b1, ainc, 28'd0, ad}, waits, drop);
        1: issue(1'b1, 1'b0, 1'b0, {1'b0, ainc, 28'd0, ad}, waits, drop);
        2: issue(1'b0, 1'b1, 1'b0, {2'b00, r[35:0]}, waits, drop);
        3: issue(1'b0, 1'b0, 1'b1, r[37:0], waits, drop);
        4: issue(1'b1, 1'b1, 1'b0, {rdnow, ainc, 28'd0, ad}, waits, drop);
        default: issue(1'b0, 1'b1, 1'b1, {2'b00, r[35:0]}, waits, drop);
      endcase
    end

    // reset on the second wait cycle of a write
    wait_idle();
    slave_waits = 255;
    @(posedge clk); #1;
    take_b = 1'b1;
    jdo = {2'b00, 4'hA, 32'hCAFE_F00D};
    be_e.is_wr = 1'b1; be_e.addr = m_addr; be_e.wdata = 32'hCAFE_F00D;
    be_e.be = 4'hA; be_e.cycles = 2;
    bus_q.push_back(be_e);
    se.mon = 32'd0; se.err = 1'b0; se.addr = 8'd0;
    st_q.push_back(se);
    @(posedge clk); #1;
    take_b = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_reset_values("midrst");
    m_addr = 8'd0; m_auto = 1'b0; m_wdata = 32'd0; m_be = 4'd0;
    m_mon = 32'd0; m_err = 1'b0;
    // first read after reset goes to address 0
    issue(1'b0, 1'b0, 1'b1, 38'd0, 1, 1'b0);

    wait_idle();
    repeat (4) @(posedge clk);
    chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    chk("status_queue_drained", 64'(st_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
